// File: rtl/aes_add_round_key_pkg.sv
// Shared AES-128 definitions: state/word typedefs, round constants and column/byte helpers.
// Used by the AddRoundKey, SubBytes, ShiftRows and MixColumns stages.
package aes_add_round_key_pkg;

    localparam int unsigned AES_NR     = 10;
    localparam int unsigned AES_NB     = 4;
    localparam int unsigned AES_WORD_W = 32;
    localparam int unsigned AES_BYTE_W = 8;

    typedef logic [127:0] aes_state_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [7:0]   aes_byte_t;

    // Entry k holds Rcon[k+1].
    localparam aes_byte_t AES_RCON [AES_NR] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Column 0 sits in the top 32 bits of the state.
    function automatic aes_word_t aes_col(input aes_state_t s, input int unsigned c);
        return aes_word_t'(s >> (AES_WORD_W * (AES_NB - 1 - c)));
    endfunction

    // Byte 0 sits in the top 8 bits of the word.
    function automatic aes_byte_t aes_word_byte(input aes_word_t w, input int unsigned b);
        return aes_byte_t'(w >> (AES_BYTE_W * (AES_NB - 1 - b)));
    endfunction

    function automatic aes_word_t aes_rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon[r] for r in 1..AES_NR, zero elsewhere.
    function automatic aes_byte_t aes_rcon(input logic [3:0] r);
        aes_byte_t rc;
        rc = '0;
        if (r != 4'd0 && r <= 4'(AES_NR)) begin
            rc = AES_RCON[r - 4'd1];
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_add_round_key_if.sv
// Valid/ready state stream into and out of the AddRoundKey stage.
interface aes_add_round_key_if;
    import aes_add_round_key_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t state_in;
    logic       out_valid;
    logic       out_ready;
    aes_state_t state_out;

    modport master (
        output in_valid,
        output state_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  state_out
    );

    modport slave (
        input  in_valid,
        input  state_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output state_out
    );

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational; shared by SubBytes and the key schedule.
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    // Row n holds S(n0)..S(nF), S(n0) in the top byte.
    localparam logic [0:15][127:0] SBOX_ROWS = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] row;

    always_comb begin
        row      = SBOX_ROWS[sbox_in[7:4]];
        sbox_out = 8'(row >> {~sbox_in[3:0], 3'b000});
    end

endmodule

// File: rtl/aes_add_round_key.sv
// Registered AddRoundKey stage with an on-the-fly AES-128 key schedule: one round key is
// consumed and the next one generated per accepted beat, wrapping to the cipher key after round 10.
module aes_add_round_key
    import aes_add_round_key_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  aes_state_t         key_in,
    aes_add_round_key_if.slave bus,
    output logic [3:0]         round_idx,
    output logic               last_round,
    output logic               key_valid
);

    aes_state_t ck_q;
    aes_state_t rk_q;
    aes_state_t rk_next;
    aes_state_t state_out_q;
    logic [3:0] round_idx_q;
    logic       key_valid_q;
    logic       out_valid_q;
    logic       in_ready;
    logic       acc;
    logic       at_last;

    aes_word_t w0, w1, w2, w3;
    aes_word_t w0n, w1n, w2n, w3n;
    aes_word_t rot_w3;
    aes_word_t t_w;
    aes_byte_t sub_b [AES_NB];

    assign w0     = aes_col(rk_q, 0);
    assign w1     = aes_col(rk_q, 1);
    assign w2     = aes_col(rk_q, 2);
    assign w3     = aes_col(rk_q, 3);
    assign rot_w3 = aes_rot_word(w3);

    for (genvar gi = 0; gi < AES_NB; gi++) begin : g_subword
        aes_sbox u_sbox (
            .sbox_in  (aes_word_byte(rot_w3, gi)),
            .sbox_out (sub_b[gi])
        );
    end

    // Next round key uses Rcon of the round it is being produced for.
    always_comb begin
        t_w     = {sub_b[0], sub_b[1], sub_b[2], sub_b[3]}
                ^ {aes_rcon(round_idx_q + 4'd1), 24'h000000};
        w0n     = w0 ^ t_w;
        w1n     = w1 ^ w0n;
        w2n     = w2 ^ w1n;
        w3n     = w3 ^ w2n;
        rk_next = {w0n, w1n, w2n, w3n};
    end

    assign at_last  = (round_idx_q == 4'(AES_NR));
    assign in_ready = key_valid_q & ~key_load & (~out_valid_q | bus.out_ready);
    assign acc      = bus.in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ck_q        <= '0;
            rk_q        <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            state_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // acc is never set in a key_load cycle, so the two branches are exclusive.
            if (key_load) begin
                ck_q        <= key_in;
                rk_q        <= key_in;
                round_idx_q <= '0;
                key_valid_q <= 1'b1;
            end else if (acc) begin
                if (at_last) begin
                    rk_q        <= ck_q;
                    round_idx_q <= '0;
                end else begin
                    rk_q        <= rk_next;
                    round_idx_q <= round_idx_q + 4'd1;
                end
            end

            if (acc) begin
                state_out_q <= bus.state_in ^ rk_q;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.state_out = state_out_q;
    assign round_idx     = round_idx_q;
    assign last_round    = at_last;
    assign key_valid     = key_valid_q;

endmodule

// File: tb/tb_aes_add_round_key.sv
// Self-checking bench for aes_add_round_key: scoreboard on the output stream plus
// direct checks of the control outputs around key loads, backpressure and reset.
module tb_aes_add_round_key;
    import aes_add_round_key_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_load;
    aes_state_t key_in;
    logic [3:0] round_idx;
    logic       last_round;
    logic       key_valid;

    aes_add_round_key_if bus ();

    aes_add_round_key dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .key_in     (key_in),
        .bus        (bus),
        .round_idx  (round_idx),
        .last_round (last_round),
        .key_valid  (key_valid)
    );

    always #5 clk = ~clk;

    localparam aes_state_t KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam aes_state_t RK_A [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam aes_state_t KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam aes_state_t RK_B1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam aes_state_t PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam aes_state_t PT_ARK = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

    int         n_cmp  = 0;
    int         n_fail = 0;
    aes_state_t exp_q [$];

    function automatic aes_state_t rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Compares every output handshake against the head of the scoreboard.
    task automatic monitor();
        aes_state_t e;
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_extra: got state_out %h, required no output",
                             bus.state_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.state_out !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard: got state_out %h, required %h",
                                 bus.state_out, e);
                    end
                end
            end
        end
    endtask

    // Called and returns at posedge+1; pushes the expectation when the beat is accepted.
    task automatic send_beat(input aes_state_t data, input aes_state_t exp);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.state_in = data;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(exp);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL send_timeout: got in_ready %b for 50 cycles, required 1", bus.in_ready);
        end
    endtask

    task automatic load_key(input aes_state_t k);
        key_load = 1'b1;
        key_in   = k;
        @(posedge clk);
        #1;
        key_load = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d outputs pending, required 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        key_load     = 1'b0;
        key_in       = '0;
        bus.in_valid = 1'b0;
        bus.state_in = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.state_out !== '0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: got state_out %h valid %b, required 0 / 0",
                     bus.state_out, bus.out_valid);
        end
        n_cmp++;
        if ({round_idx, last_round, key_valid, bus.in_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got idx %0d last %b kv %b ready %b, required 0 0 0 0",
                     round_idx, last_round, key_valid, bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_no_key();
        bus.in_valid  = 1'b1;
        bus.state_in  = rand128();
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL no_key: got in_ready %b out_valid %b, required 0 0",
                         bus.in_ready, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_key_schedule();
        logic exp_last;
        bus.out_ready = 1'b1;
        key_load      = 1'b1;
        key_in        = KEY_A;
        bus.in_valid  = 1'b1;
        bus.state_in  = '0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL keyload_in_ready: got %b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        key_load     = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (key_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL keyload_key_valid: got %b, required 1", key_valid);
        end
        for (int i = 0; i < 11; i++) begin
            exp_last = (i == 10);
            n_cmp++;
            if (round_idx !== 4'(i) || last_round !== exp_last) begin
                n_fail++;
                $display("FAIL sched_idx%0d: got idx %0d last %b, required %0d %b",
                         i, round_idx, last_round, i, exp_last);
            end
            send_beat('0, RK_A[i]);
        end
        wait_drain("sched");
        n_cmp++;
        if (round_idx !== 4'd0 || last_round !== 1'b0) begin
            n_fail++;
            $display("FAIL sched_wrap: got idx %0d last %b, required 0 0", round_idx, last_round);
        end
    endtask

    task automatic test_plaintext();
        aes_state_t x;
        send_beat(PT, PT_ARK);
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.state_out !== PT_ARK) begin
            n_fail++;
            $display("FAIL pt_latency: got valid %b state_out %h, required 1 %h",
                     bus.out_valid, bus.state_out, PT_ARK);
        end
        x = rand128();
        send_beat(x, x ^ RK_A[1]);
        wait_drain("pt");
    endtask

    task automatic test_backpressure();
        aes_state_t a, b;
        load_key(KEY_A);
        a             = rand128();
        bus.out_ready = 1'b0;
        send_beat(a, a ^ RK_A[0]);
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold: got in_ready %b out_valid %b, required 0 1",
                         bus.in_ready, bus.out_valid);
            end
            n_cmp++;
            if (bus.state_out !== (a ^ RK_A[0]) || round_idx !== 4'd1) begin
                n_fail++;
                $display("FAIL bp_stable: got state_out %h idx %0d, required %h 1",
                         bus.state_out, round_idx, a ^ RK_A[0]);
            end
        end
        @(posedge clk);
        #1;
        b             = rand128();
        bus.out_ready = 1'b1;
        send_beat(b, b ^ RK_A[1]);
        wait_drain("bp");
    endtask

    task automatic test_key_reload();
        aes_state_t c;
        load_key(KEY_A);
        for (int i = 0; i < 5; i++) begin
            c = rand128();
            send_beat(c, c ^ RK_A[i]);
        end
        bus.out_ready = 1'b0;
        key_load      = 1'b1;
        key_in        = KEY_B;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_in_ready: got %b, required 0", bus.in_ready);
        end
        @(posedge clk);
        #1;
        key_load = 1'b0;
        n_cmp++;
        if (round_idx !== 4'd0 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_state: got idx %0d out_valid %b, required 0 1",
                     round_idx, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        c = rand128();
        send_beat(c, c ^ KEY_B);
        c = rand128();
        send_beat(c, c ^ RK_B1);
        wait_drain("reload");
    endtask

    task automatic test_reset_mid();
        aes_state_t x;
        load_key(KEY_A);
        x             = rand128();
        bus.out_ready = 1'b0;
        send_beat(x, x ^ RK_A[0]);
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got out_valid %b, required 1", bus.out_valid);
        end
        rst          = 1'b1;
        key_load     = 1'b1;
        key_in       = KEY_B;
        bus.in_valid = 1'b1;
        bus.state_in = rand128();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst          = 1'b0;
        key_load     = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.state_out !== '0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_out: got state_out %h valid %b, required 0 / 0",
                     bus.state_out, bus.out_valid);
        end
        n_cmp++;
        if ({round_idx, last_round, key_valid, bus.in_ready} !== 7'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got idx %0d last %b kv %b ready %b, required 0 0 0 0",
                     round_idx, last_round, key_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rstmid_nokey: got in_ready %b out_valid %b, required 0 0",
                         bus.in_ready, bus.out_valid);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_no_key();
        test_key_schedule();
        test_plaintext();
        test_backpressure();
        test_key_reload();
        test_reset_mid();
        wait_drain("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
